// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with synchronous clear/load, a combinational
// terminal-count flag and a registered wrap/saturate pulse.
module updown_mod_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             S,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic at_top;
    logic at_bot;

    // Out-of-range load values land on the top of the range, never beyond it.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > TOP) ? TOP : v;
    endfunction

    // The end-of-range case either wraps or holds; the interior always moves by one.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur,
                                              input logic            up,
                                              input logic            at_end);
        logic [WIDTH-1:0] nxt;
        if (at_end) begin
            if (SATURATE != 0) nxt = cur;
            else               nxt = up ? '0 : TOP;
        end else begin
            nxt = up ? cur + ONE : cur - ONE;
        end
        return nxt;
    endfunction

    assign at_top = (Q == TOP);
    assign at_bot = (Q == '0);
    assign tc     = en & ((S & at_top) | (~S & at_bot));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            Q    <= clamp_load(load_val);
            wrap <= 1'b0;
        end else if (en) begin
            Q    <= step(Q, S, tc);
            wrap <= tc;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: three instances (mod-8 wrap, mod-6 wrap,
// mod-6 saturate) driven from one directed vector table.
module tb_updown_mod_counter;

    typedef struct {
        int         inst;
        bit         rst, clr, ld;
        logic [2:0] lv;
        bit         en, s;
        logic [2:0] q;
        bit         w, tc;
    } vec_t;

    typedef struct {
        int         idx;
        int         inst;
        logic [2:0] q;
        bit         w, tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_i  [3];
    logic       en_i [3];
    logic       clr_i[3];
    logic       ld_i [3];
    logic [2:0] lv_i [3];
    logic [2:0] q_o  [3];
    logic       tc_o [3];
    logic       w_o  [3];

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_m8 (
        .clk(clk), .reset(reset), .S(s_i[0]), .en(en_i[0]), .clear(clr_i[0]),
        .load(ld_i[0]), .load_val(lv_i[0]), .Q(q_o[0]), .tc(tc_o[0]), .wrap(w_o[0]));

    updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_m6w (
        .clk(clk), .reset(reset), .S(s_i[1]), .en(en_i[1]), .clear(clr_i[1]),
        .load(ld_i[1]), .load_val(lv_i[1]), .Q(q_o[1]), .tc(tc_o[1]), .wrap(w_o[1]));

    updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_m6s (
        .clk(clk), .reset(reset), .S(s_i[2]), .en(en_i[2]), .clear(clr_i[2]),
        .load(ld_i[2]), .load_val(lv_i[2]), .Q(q_o[2]), .tc(tc_o[2]), .wrap(w_o[2]));

    // Row: inputs applied for one cycle, plus the Q/wrap/tc expected during that cycle.
    task automatic add(input int inst, input int rst, input int clr, input int ld,
                       input int lv, input int en, input int s,
                       input int q, input int w, input int tc);
        vec_t v;
        v.inst = inst; v.rst = (rst != 0); v.clr = (clr != 0); v.ld = (ld != 0);
        v.lv = 3'(lv); v.en = (en != 0); v.s = (s != 0);
        v.q = 3'(q); v.w = (w != 0); v.tc = (tc != 0);
        vecs.push_back(v);
    endtask

    task automatic build_table();
        // mod-8 wrap: reset tc, count up through 7->0, down through 0->7
        add(0, 0,0,0,0, 1,0, 0,0,1);
        add(0, 1,0,0,0, 1,1, 0,0,0);
        for (int q = 1; q <= 6; q++) add(0, 1,0,0,0, 1,1, q,0,0);
        add(0, 1,0,0,0, 1,1, 7,0,1);
        add(0, 1,0,0,0, 1,1, 0,1,0);
        add(0, 1,0,0,0, 1,1, 1,0,0);
        add(0, 1,1,0,0, 1,1, 2,0,0);
        add(0, 1,0,0,0, 1,0, 0,0,1);
        add(0, 1,0,0,0, 1,0, 7,1,0);
        add(0, 1,0,0,0, 1,0, 6,0,0);
        add(0, 1,0,0,0, 0,0, 5,0,0);
        // async reset between edges while Q=5, then resume from 0
        add(0, 0,0,0,0, 1,1, 0,0,0);
        add(0, 1,0,0,0, 1,1, 0,0,0);
        add(0, 1,0,0,0, 0,0, 1,0,0);
        // priority: clear over load over en; load with en takes no step
        add(0, 1,1,1,4, 1,1, 1,0,0);
        add(0, 1,0,1,4, 1,1, 0,0,0);
        add(0, 1,0,0,0, 0,0, 4,0,0);
        // mod-6 wrap: load clamp, up wrap, reload, down wrap
        add(1, 1,0,1,7, 0,0, 0,0,0);
        add(1, 1,0,0,0, 1,1, 5,0,1);
        add(1, 1,0,1,3, 0,0, 0,1,0);
        add(1, 1,0,0,0, 1,0, 3,0,0);
        add(1, 1,1,0,0, 0,0, 2,0,0);
        add(1, 1,0,0,0, 1,0, 0,0,1);
        add(1, 1,1,0,0, 0,0, 5,1,0);
        add(1, 1,0,1,6, 0,0, 0,0,0);
        add(1, 1,0,0,0, 0,0, 5,0,0);
        // mod-6 saturate: hold at top with repeated wrap pulses, hold at bottom
        add(2, 1,0,1,4, 0,0, 0,0,0);
        add(2, 1,0,0,0, 1,1, 4,0,0);
        add(2, 1,0,0,0, 1,1, 5,0,1);
        add(2, 1,0,0,0, 1,1, 5,1,1);
        add(2, 1,0,0,0, 1,1, 5,1,1);
        add(2, 1,1,0,0, 1,1, 5,1,1);
        add(2, 1,0,0,0, 1,0, 0,0,1);
        add(2, 1,0,0,0, 1,0, 0,1,1);
        add(2, 1,0,0,0, 0,0, 0,1,0);
        add(2, 1,0,0,0, 0,0, 0,0,0);
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            s_i[i] = 1'b0; en_i[i] = 1'b0; clr_i[i] = 1'b0;
            ld_i[i] = 1'b0; lv_i[i] = 3'd0;
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so compare every pending entry there.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (q_o[e.inst] === e.q && w_o[e.inst] === e.w && tc_o[e.inst] === e.tc) begin
                    n_pass++;
                end else begin
                    $display("FAIL row%0d inst%0d: got Q=%0d wrap=%b tc=%b, want Q=%0d wrap=%b tc=%b",
                             e.idx, e.inst, q_o[e.inst], w_o[e.inst], tc_o[e.inst],
                             e.q, e.w, e.tc);
                end
            end
        end
    end

    initial begin
        idle_all();
        reset = 1'b0;
        build_table();
        for (int r = 0; r < vecs.size(); r++) begin
            vec_t v;
            exp_t e;
            v = vecs[r];
            @(posedge clk);
            #1;
            idle_all();
            reset            = v.rst;
            s_i[v.inst]      = v.s;
            en_i[v.inst]     = v.en;
            clr_i[v.inst]    = v.clr;
            ld_i[v.inst]     = v.ld;
            lv_i[v.inst]     = v.lv;
            e.idx = r; e.inst = v.inst; e.q = v.q; e.w = v.w; e.tc = v.tc;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 3, giving the count register width in bits (legal: WIDTH >= 1).
REQ-002 The module SHALL have parameter MODULUS, default 8, giving the count range 0..MODULUS-1 (legal: 2 <= MODULUS <= 2**WIDTH).
REQ-003 The module SHALL have parameter SATURATE, default 0, where 0 means wrap at the range ends and 1 means hold at the range ends.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  asynchronous, active-low reset; reset=0 SHALL clear all state immediately, independent of clk.
REQ-006 S  input  1  direction select; 1 = up count, 0 = down count.
REQ-007 en  input  1  count enable; the counter SHALL step only when en=1.
REQ-008 clear  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value written on load.
REQ-011 Q  output  WIDTH  registered count value.
REQ-012 tc  output  1  combinational terminal count, meaning the next enabled step crosses a range end.
REQ-013 wrap  output  1  registered one-cycle pulse, meaning the previous edge wrapped or saturated.

Function
REQ-014 All flops SHALL be in one clock domain, with no derived or gated clocks (fully synchronous counting).
REQ-015 Per-edge priority SHALL be: clear > load > en; with all three low, Q SHALL hold.
REQ-016 On clear=1, Q SHALL become 0 and wrap SHALL be 0.
REQ-017 On load=1 with clear=0:
  - Q SHALL become load_val when load_val <= MODULUS-1.
  - Otherwise Q SHALL become MODULUS-1 (clamp).
  - wrap SHALL be 0.
REQ-018 On en=1 and S=1 with Q < MODULUS-1, Q SHALL increment by 1.
REQ-019 On en=1 and S=0 with Q > 0, Q SHALL decrement by 1.
REQ-020 On en=1, S=1 and Q = MODULUS-1:
  - SATURATE=0: Q SHALL become 0.
  - SATURATE=1: Q SHALL hold MODULUS-1.
  - In both cases wrap SHALL be 1 on the following cycle.
REQ-021 On en=1, S=0 and Q = 0:
  - SATURATE=0: Q SHALL become MODULUS-1.
  - SATURATE=1: Q SHALL hold 0.
  - In both cases wrap SHALL be 1 on the following cycle.
REQ-022 tc SHALL equal en & ((S & Q==MODULUS-1) | (~S & Q==0)), with no registering, so tc is valid in the same cycle as the inputs.
REQ-023 wrap SHALL be high for exactly one cycle per range-end event, and SHALL be 0 on every other edge.
REQ-024 A change of S SHALL take effect on the next rising edge with no glitch step; Q SHALL change by at most one count per edge.
REQ-025 Arithmetic SHALL be WIDTH bits wide; Q SHALL never hold a value >= MODULUS after any edge, including when MODULUS < 2**WIDTH.
REQ-026 clear and load asserted together SHALL yield Q=0; load with en=1 SHALL yield the loaded value, with no step applied.

Reset
REQ-027 While reset=0, Q SHALL be 0 and wrap SHALL be 0, asynchronously, regardless of clk and all other inputs.
REQ-028 tc SHALL follow REQ-022 during reset (Q=0), so tc=1 if en=1 and S=0.
REQ-029 Reset asserted mid-count SHALL force Q=0 within the same cycle, and counting SHALL resume from 0 on the first rising edge after reset returns to 1.
REQ-030 No state other than Q and wrap SHALL exist.

Verification
REQ-031 WIDTH=3, MODULUS=8, SATURATE=0; reset released, en=1, S=1, 10 edges -> Q = 1,2,...,7,0,1,2; wrap=1 exactly in the cycle after 7->0; tc=1 while Q=7.
REQ-032 Same parameters; en=1, S=0 from Q=0, 3 edges -> Q = 7,6,5; wrap pulses once after 0->7; tc=1 while Q=0.
REQ-033 WIDTH=3, MODULUS=6, SATURATE=0; load with load_val=7 -> Q=5; then S=1 for 1 edge -> Q=0 with a wrap pulse; load_val=3 -> Q=3.
REQ-034 WIDTH=3, MODULUS=6, SATURATE=1; up from Q=4, 3 edges -> Q = 5,5,5; wrap=1 after each held edge; down from 0 -> Q holds 0.
REQ-035 Priority: clear=1, load=1, load_val=4, en=1 on one edge -> Q=0; then load=1, en=1, load_val=4 -> Q=4, with no step applied.
REQ-036 reset driven 0 between clock edges while Q=5 -> Q=0 and wrap=0 before the next edge; after release with en=1, S=1, the first edge gives Q=1.
